// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 size codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extraction/extension, store merge, request legality.
// Optional feature: LSU_MISALIGN_TRAP_EN turns misaligned H/HU/SH/W/SW into faults.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] merged,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        illegal;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replace the addressed lane of the captured word with the store data.
  always_comb begin
    merged = rdata;
    case (funct3)
      F3_B: begin
        case (addr)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  // Reject reserved codes and unsigned stores; optionally misaligned accesses too.
  always_comb begin
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = store;
      default:          illegal = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    fault = illegal
          | (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
          | ((funct3 == F3_W) && (addr != 2'b00));
`else
    fault = illegal;
`endif
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: request/response handshake around a word-wide data memory,
// sub-word stores done as read-modify-write. Optional: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state, state_next;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_q;
  logic [31:0] wdata_q;
  logic        latch;

  logic        req_ready_n, resp_valid_n, resp_fault_n, mem_write_n;
  logic [31:0] resp_rdata_n, mem_addr_n, mem_write_data_n;

  logic        lane_store;
  logic [2:0]  lane_funct3;
  logic [1:0]  lane_addr;
  logic [31:0] lane_wdata, load_data, merged;
  logic        fault;

  // Legality is judged on the live request in IDLE, lane work on the latched one.
  assign lane_store  = (state == IDLE) ? req_store       : store_q;
  assign lane_funct3 = (state == IDLE) ? req_funct3      : funct3_q;
  assign lane_addr   = (state == IDLE) ? req_addr[1:0]   : addr_q;
  assign lane_wdata  = (state == IDLE) ? req_wdata       : wdata_q;

  lsu_byte_lane u_lane (
    .store     (lane_store),
    .funct3    (lane_funct3),
    .addr      (lane_addr),
    .wdata     (lane_wdata),
    .rdata     (mem_read_data),
    .load_data (load_data),
    .merged    (merged),
    .fault     (fault)
  );

  // Next state and next value of every registered output.
  always_comb begin
    state_next       = state;
    latch            = 1'b0;
    req_ready_n      = 1'b0;
    resp_valid_n     = 1'b0;
    resp_fault_n     = 1'b0;
    resp_rdata_n     = 32'd0;
    mem_addr_n       = 32'd0;
    mem_write_n      = 1'b0;
    mem_write_data_n = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          latch = 1'b1;
          if (fault) begin
            state_next   = RESP;
            resp_valid_n = 1'b1;
            resp_fault_n = 1'b1;
          end else begin
            state_next = ACCESS;
            mem_addr_n = {req_addr[31:2], 2'b00};
          end
        end else begin
          req_ready_n = 1'b1;
        end
      end
      ACCESS: begin
        if (store_q) begin
          state_next       = WRITE;
          mem_addr_n       = mem_addr;
          mem_write_n      = 1'b1;
          mem_write_data_n = merged;
        end else begin
          state_next   = RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = load_data;
        end
      end
      WRITE: begin
        state_next   = RESP;
        resp_valid_n = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_next  = IDLE;
          req_ready_n = 1'b1;
        end else begin
          resp_valid_n = 1'b1;
          resp_rdata_n = resp_rdata;
          resp_fault_n = resp_fault;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, dropping mem_write at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_fault     <= 1'b0;
      resp_rdata     <= 32'd0;
      mem_addr       <= 32'd0;
      mem_write      <= 1'b0;
      mem_write_data <= 32'd0;
    end else begin
      state          <= state_next;
      req_ready      <= req_ready_n;
      resp_valid     <= resp_valid_n;
      resp_fault     <= resp_fault_n;
      resp_rdata     <= resp_rdata_n;
      mem_addr       <= mem_addr_n;
      mem_write      <= mem_write_n;
      mem_write_data <= mem_write_data_n;
    end
  end

  // Capture the accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 2'd0;
      wdata_q  <= 32'd0;
    end else if (latch) begin
      store_q  <= req_store;
      funct3_q <= req_funct3;
      addr_q   <= req_addr[1:0];
      wdata_q  <= req_wdata;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the word-wide data-memory port: accepts RV32 load/store requests from the core, drives the word-addressed memory (combinational read, write committed on the falling clock edge while write is asserted), and implements byte/halfword access by lane extraction and read-modify-write. It sits between the core's execute stage and data memory and returns one response per request over a valid/ready handshake.

## Interface
- No parameters; widths fixed at 32 bits.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; low bits are used for B/H.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: core accepts the response.
- `resp_rdata` out 32: load result; 0 for stores and faults.
- `resp_fault` out 1: request rejected; no memory side effect.
- `mem_addr` out 32: byte address with bits [1:0] forced to 00.
- `mem_write` out 1: write enable.
- `mem_write_data` out 32: merged word.
- `mem_read_data` in 32: combinational read of `mem_addr`.

## Operation
- **States:** IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: latch store, funct3, addr and wdata.
  - Illegal code (011, 110, 111, or store with 100/101): go to RESP with fault.
  - Misaligned and `LSU_MISALIGN_TRAP_EN` defined: go to RESP with fault.
  - Otherwise: go to ACCESS.
- **ACCESS**
  - Drive `mem_addr`; `mem_write` = 0.
  - Register `mem_read_data`.
  - Load: register the extracted result, then go to RESP.
  - Store: go to WRITE.
- **WRITE**
  - `mem_write` = 1.
  - `mem_write_data` = captured word with the addressed lane replaced: byte lane `addr[1:0]`, halfword lane `addr[1]`, word = full `wdata`.
  - SW also passes through ACCESS, so every store has the same latency.
  - Then go to RESP.
- **RESP**
  - `resp_valid` = 1; outputs are held stable until `resp_ready`, then go to IDLE.
  - There is no same-cycle re-accept: `req_ready` = 0 outside IDLE.
- **Load extraction**
  - B/BU take the byte at `addr[1:0]*8`; H/HU take the halfword at `addr[1]*16`.
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- **Outputs outside their active state:** `mem_write` = 0, `mem_write_data` = 0, `mem_addr` = 0 in IDLE.

## Timing
- **Reset:** state IDLE.
  - `req_ready` = 0 while `reset` is high, and 1 from the first edge after reset is released.
  - `resp_valid`, `resp_fault`, `resp_rdata`, `mem_write`, `mem_addr` and `mem_write_data` are all 0.
- **Latency from the accepting edge to `resp_valid`:**
  - Load: 2 cycles.
  - Store: 3 cycles.
  - Fault: 1 cycle.
- **Write timing:** the memory write lands on the falling edge inside the WRITE cycle, so a load issued immediately afterwards observes it.
- **Reset mid-operation:** `mem_write` drops asynchronously. Reset asserted before the WRITE-cycle falling edge suppresses the write, and the in-flight request is discarded with no response.
- **Backpressure:** with `resp_ready` low, RESP is held indefinitely and `resp_rdata`/`resp_fault` stay constant.

## Configuration
- **Macro:** `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - H/HU/SH with `addr[0]` = 1 → fault.
  - W/SW with `addr[1:0]` ≠ 00 → fault.
  - A faulting request makes no memory access.
- **Undefined:**
  - Misalignment is not detected.
  - H ignores `addr[0]`; W ignores `addr[1:0]`.
  - Faults come only from illegal codes.

## Structure
- **Package `lsu_pkg`:** funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum `lsu_state_t`.
- **Sub-module `lsu_byte_lane` (combinational):**
  - Load extraction and sign/zero extension.
  - Store lane merge.
  - Misalignment/illegal-code detection.
- The FSM, request/response registers and handshake stay in `load_store_unit`.

## Test plan
- **SW and LW:** reset, then SW 0xA1B2C3D4 @0x10, then LW @0x10 → `resp_rdata` 0xA1B2C3D4. Store response after 3 cycles, load response after 2.
- **Sign/zero extension:** on that word:
  - LB @0x13 → 0xFFFFFFA1.
  - LBU @0x12 → 0x000000B2.
  - LH @0x12 → 0xFFFFA1B2.
  - LHU @0x10 → 0x0000C3D4.
- **Sub-word merges:**
  - SB 0x5A @0x11, then LW @0x10 → 0xA1B25AD4.
  - SH 0x1234 @0x12, then LW @0x10 → 0x12345AD4.
- **Misaligned LW @0x12:**
  - With the macro: fault = 1 after 1 cycle, `mem_write` never high, word unchanged.
  - Without the macro: returns the word @0x10.
- **Illegal code:** funct3 = 011 → fault = 1, rdata = 0, no memory access. Store with funct3 = 100 → fault = 1.
- **Backpressure and reset:**
  - Hold `resp_ready` low 3 cycles → `resp_valid`/`resp_rdata` stable and `req_ready` = 0.
  - Assert `reset` during WRITE, before the falling edge → memory unchanged, all outputs 0.
